sram_rmw_controller: RTL

Single-requester access sequencer for the single-port SRAM macro in the SRAM controller. Bus-side words are little-endian, and SRAM storage is big-endian. Every word crossing the block is byte-swapped (bus byte k ↔ SRAM byte 3-k). Partial-word writes are turned into a read-modify-write sequence, because the macro has no byte enables.

---
 rtl/sram_rmw_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sram_rmw_controller.sv
// Purpose: sequences single-port SRAM accesses; byte-swaps bus<->SRAM words, turns partial writes into read-modify-write.
// Latency: read done N+2+L, full write N+2, partial write N+3+L, zero-enable write N+1 (N = accepting IDLE cycle).
// Backpressure: req_busy high outside IDLE; requests presented while busy are ignored and must be re-presented.
module sram_rmw_controller #(
  parameter int ADDR_WIDTH   = 12,
  parameter int SRAM_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_ren,
  input  logic                  req_wen,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_byte_en,
  output logic                  req_busy,
  output logic                  req_done,
  output logic [31:0]           req_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ren,
  output logic                  sram_wen,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, CAPTURE, WR, DONE} state_t;

  // Cycles spent waiting after the read strobe before data is sampled.
  localparam logic [1:0] LAT_M1 = 2'(SRAM_LATENCY - 1);

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;   // bus order; becomes the merged word during RMW
  logic [3:0]            lat_be;
  logic                  lat_wr;
  logic [31:0]           rdata_bus;
  logic [31:0]           merged;

  // Byte k of the result is byte 3-k of the input.
  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign rdata_bus = swap(sram_rdata);

  // Merge: enabled bytes from the request, the rest from the SRAM word.
  always_comb begin
    merged = rdata_bus;
    for (int k = 0; k < 4; k++) begin
      if (lat_be[k]) merged[8*k +: 8] = lat_wdata[8*k +: 8];
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_wen) begin
          if (req_byte_en == 4'hF)      state_nxt = WR;
          else if (req_byte_en == 4'h0) state_nxt = DONE;
          else                          state_nxt = RD;
        end else if (req_ren) begin
          state_nxt = RD;
        end
      end
      RD:      state_nxt = (LAT_M1 != 2'd0) ? RD_WAIT : CAPTURE;
      RD_WAIT: if (lat_cnt == 2'd1) state_nxt = CAPTURE;
      CAPTURE: state_nxt = lat_wr ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter, merge and read-data registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_cnt   <= 2'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      lat_wr    <= 1'b0;
      req_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_wen || req_ren) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_byte_en;
            lat_wr    <= req_wen;
          end
        end
        RD:      lat_cnt <= LAT_M1;
        RD_WAIT: lat_cnt <= lat_cnt - 2'd1;
        CAPTURE: begin
          if (lat_wr) lat_wdata <= merged;
          else        req_rdata <= rdata_bus;
        end
        default: ;
      endcase
    end
  end

  // Strobes and SRAM-side outputs decoded from the state.
  always_comb begin
    req_busy   = (state != IDLE);
    req_done   = (state == DONE);
    sram_ren   = (state == RD);
    sram_wen   = (state == WR);
    sram_addr  = (state == IDLE) ? '0 : lat_addr;
    sram_wdata = (state == WR) ? swap(lat_wdata) : 32'd0;
  end

endmodule
